// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the WISC fetch stage: default parameters and the
// fetch FSM state type.
package fetch_stage_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [4:0]  HALT_OPC_DEF = 5'b00000;

  // S_FETCH: request outstanding; S_HOLD: response parked while the slot is
  // stalled; S_HALT: HALT reached ID, no further fetching.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
//   imem_req   : fetch request valid (master -> slave)
//   imem_addr  : fetch address       (master -> slave)
//   imem_rdy   : response valid      (slave -> master)
//   imem_rdata : instruction word    (slave -> master)
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_rdy;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rdy, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rdy, imem_rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline slot: load has priority over clear, otherwise hold.
//   clk, rst_n         : clock, async active-low reset
//   load, clear        : write a new instruction / invalidate the slot
//   instr_in, pc2_in   : instruction and its fetch PC + 2
//   valid, instr, pc2  : registered slot contents
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc2_in,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc2
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc2   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc2   <= pc2_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the 16-bit WISC core.
//   clk, rst_n   : clock, async active-low reset
//   imem         : instruction-memory bus (master side)
//   stall        : hazard unit holds the IF/ID slot
//   redirect     : taken branch/jump, target in redirect_pc
//   id_valid, id_instr, id_opcode, id_pc_plus2 : IF/ID slot outputs
//   halted       : HALT has entered ID, fetch stopped
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [4:0]        HALT_OPC = HALT_OPC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [DATA_W-1:0]    redirect_pc,
  output logic                 id_valid,
  output logic [DATA_W-1:0]    id_instr,
  output logic [4:0]           id_opcode,
  output logic [DATA_W-1:0]    id_pc_plus2,
  output logic                 halted
);

  fetch_state_e      state, state_n;
  logic              run;
  logic              squash, squash_n;
  logic              halted_n;
  logic [DATA_W-1:0] pc, pc_n, pc_inc;
  logic [DATA_W-1:0] target, target_n;
  logic [DATA_W-1:0] hold_instr, hold_instr_n;
  logic [DATA_W-1:0] hold_pc2, hold_pc2_n;
  logic              slot_load, slot_clear;
  logic [DATA_W-1:0] slot_instr, slot_pc2;
  logic              xfer, accept;

  // run keeps the request low until the first edge after reset release.
  assign imem.imem_req  = run && (state == S_FETCH);
  assign imem.imem_addr = pc;

  assign xfer   = imem.imem_req && imem.imem_rdy;
  assign accept = !id_valid || !stall;
  assign pc_inc = pc + DATA_W'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      run        <= 1'b0;
      pc         <= RESET_PC;
      squash     <= 1'b0;
      target     <= '0;
      hold_instr <= '0;
      hold_pc2   <= '0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      run        <= 1'b1;
      pc         <= pc_n;
      squash     <= squash_n;
      target     <= target_n;
      hold_instr <= hold_instr_n;
      hold_pc2   <= hold_pc2_n;
      halted     <= halted_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    squash_n     = squash;
    target_n     = target;
    hold_instr_n = hold_instr;
    hold_pc2_n   = hold_pc2;
    halted_n     = halted;
    slot_load    = 1'b0;
    slot_clear   = !stall;   // consumed by decode unless a new word lands
    slot_instr   = imem.imem_rdata;
    slot_pc2     = pc_inc;

    if (redirect) begin
      slot_clear   = 1'b1;
      hold_instr_n = '0;
      hold_pc2_n   = '0;
      if (state == S_FETCH && imem.imem_req && !xfer) begin
        // The outstanding request cannot be withdrawn: remember the target
        // and throw away whatever it eventually returns.
        squash_n = 1'b1;
        target_n = redirect_pc;
      end else begin
        pc_n     = redirect_pc;
        squash_n = 1'b0;
        state_n  = S_FETCH;
        halted_n = 1'b0;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (xfer) begin
            if (squash) begin
              pc_n     = target;
              squash_n = 1'b0;
            end else begin
              pc_n = pc_inc;
              if (accept) begin
                slot_load = 1'b1;
                if (imem.imem_rdata[DATA_W-1 -: 5] == HALT_OPC) begin
                  state_n  = S_HALT;
                  halted_n = 1'b1;
                end
              end else begin
                hold_instr_n = imem.imem_rdata;
                hold_pc2_n   = pc_inc;
                state_n      = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (accept) begin
            slot_load  = 1'b1;
            slot_instr = hold_instr;
            slot_pc2   = hold_pc2;
            if (hold_instr[DATA_W-1 -: 5] == HALT_OPC) begin
              state_n  = S_HALT;
              halted_n = 1'b1;
            end else begin
              state_n = S_FETCH;
            end
          end
        end
        S_HALT: ;
        default: state_n = S_FETCH;
      endcase
    end
  end

  if_id_reg #(.DATA_W(DATA_W)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (slot_load),
    .clear    (slot_clear),
    .instr_in (slot_instr),
    .pc2_in   (slot_pc2),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc2      (id_pc_plus2)
  );

  assign id_opcode = id_instr[DATA_W-1 -: 5];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [4:0]  HALT   = 5'b00000;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [4:0]  id_opcode;
  logic [15:0] id_pc_plus2;
  logic        halted;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_consumed = 0;
  int          max_lat  = 0;

  exp_t        exp_q[$];
  logic [15:0] gen_pc;
  bit          gen_live = 1'b0;

  fetch_stage_if #(.DATA_W(16)) bus ();

  fetch_stage #(.DATA_W(16), .RESET_PC(RST_PC), .HALT_OPC(HALT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode),
    .id_pc_plus2 (id_pc_plus2),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Program image: ADDI words at 0x0..0xE except a HALT word at 0x0008;
  // elsewhere hashed words with a HALT every 256 bytes.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [15:0] h;
    logic [4:0]  opc;
    if (a == 16'h0008) return 16'h0000;
    if (a < 16'h0010) return {5'b01000, a[10:0]};
    h   = a * 16'd37 + 16'd11;
    opc = h[12:8];
    if (a[7:0] == 8'hA0) opc = HALT;
    else if (opc == HALT) opc = 5'b00001;
    return {opc, a[10:0] ^ 11'h5a3};
  endfunction

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Sequential program flow from the current stream point until a HALT.
  task automatic extend();
    logic [15:0] w;
    while (gen_live && exp_q.size() < 64) begin
      w = word_at(gen_pc);
      exp_q.push_back('{instr: w, pc2: gen_pc + 16'd2});
      if (w[15:11] == HALT) gen_live = 1'b0;
      gen_pc = gen_pc + 16'd2;
    end
  endtask

  task automatic restart(input logic [15:0] start);
    exp_q.delete();
    gen_pc   = start;
    gen_live = 1'b1;
    extend();
  endtask

  task automatic step_random();
    logic [15:0] t;
    @(negedge clk);
    stall    = ($urandom_range(0, 3) == 0);
    redirect = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
    if (redirect) begin
      t = 16'($urandom);
      if ($urandom_range(0, 3) == 0) t = {12'hFFF, t[3:0]};
      t[0] = 1'b0;
      redirect_pc = t;
      restart(t);
    end
    extend();
  endtask

  // Memory responder: random latency, rdata only meaningful with rdy.
  initial begin
    int lat;
    lat = 0;
    bus.imem_rdy   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || !bus.imem_req) begin
        bus.imem_rdy   = 1'b0;
        bus.imem_rdata = 16'($urandom);
      end else if (lat == 0) begin
        bus.imem_rdy   = 1'b1;
        bus.imem_rdata = word_at(bus.imem_addr);
      end else begin
        bus.imem_rdy   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        lat--;
      end
      #4;
      if (bus.imem_req && bus.imem_rdy) lat = $urandom_range(0, max_lat);
    end
  end

  // Monitor: an instruction is consumed on an edge where the slot is valid,
  // not stalled and not flushed by a redirect.
  initial begin
    bit          pend;
    logic [15:0] pend_addr;
    exp_t        e;
    pend = 1'b0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n !== 1'b1) begin
        pend = 1'b0;
      end else begin
        if (pend)
          check("req_stable", bus.imem_req && bus.imem_addr == pend_addr,
                {15'd0, bus.imem_req, bus.imem_addr}, {15'd0, 1'b1, pend_addr});
        pend      = bus.imem_req && !bus.imem_rdy;
        pend_addr = bus.imem_addr;
        if (halted)
          check("halt_no_req", !bus.imem_req, 32'(bus.imem_req), 32'd0);
        if (id_valid && !stall && !redirect) begin
          n_consumed++;
          check("queue_nonempty", exp_q.size() != 0, 32'(id_pc_plus2), 32'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("id_instr", id_instr == e.instr, 32'(id_instr), 32'(e.instr));
            check("id_pc_plus2", id_pc_plus2 == e.pc2, 32'(id_pc_plus2), 32'(e.pc2));
            check("id_opcode", id_opcode == e.instr[15:11],
                  32'(id_opcode), 32'(e.instr[15:11]));
            check("halted_flag", halted == (e.instr[15:11] == HALT),
                  32'(halted), 32'(e.instr[15:11] == HALT));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", !bus.imem_req, 32'(bus.imem_req), 32'd0);
    check("rst_id_valid", !id_valid, 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr == 16'd0, 32'(id_instr), 32'd0);
    check("rst_id_pc2", id_pc_plus2 == 16'd0, 32'(id_pc_plus2), 32'd0);
    check("rst_halted", !halted, 32'(halted), 32'd0);

    // Zero-latency streaming from reset into the HALT at 0x0008.
    repeat (2) @(negedge clk);
    restart(RST_PC);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #4;
      check("stream_addr", bus.imem_req && bus.imem_addr == 16'(2 * k),
            {15'd0, bus.imem_req, bus.imem_addr}, {16'd1, 16'(2 * k)});
      if (k >= 1) begin
        check("stream_valid", id_valid, 32'(id_valid), 32'd1);
        check("stream_opc", id_opcode == 5'b01000, 32'(id_opcode), 32'h08);
      end
    end
    @(negedge clk);
    #4;
    check("halt_set", halted && id_valid, {30'd0, halted, id_valid}, 32'd3);
    check("halt_opc", id_opcode == HALT, 32'(id_opcode), 32'(HALT));
    check("halt_req_off", !bus.imem_req, 32'(bus.imem_req), 32'd0);

    // Redirect out of HALT.
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    restart(16'h0010);
    @(negedge clk);
    redirect = 1'b0;
    #4;
    check("unhalt", !halted, 32'(halted), 32'd0);
    check("unhalt_addr", bus.imem_req && bus.imem_addr == 16'h0010,
          {15'd0, bus.imem_req, bus.imem_addr}, {16'd1, 16'h0010});

    // PC wrap past 0xFFFE.
    repeat (2) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'hFFFC;
    restart(16'hFFFC);
    @(negedge clk);
    redirect = 1'b0;
    extend();
    repeat (2) @(negedge clk);
    #4;
    check("wrap_addr", bus.imem_addr == 16'h0000, 32'(bus.imem_addr), 32'd0);
    repeat (4) begin
      @(negedge clk);
      extend();
    end

    // Random latency, stalls and redirects.
    max_lat = 3;
    repeat (1500) step_random();

    // Asynchronous reset in the middle of traffic.
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    gen_live = 1'b0;
    #1;
    check("arst_req", !bus.imem_req, 32'(bus.imem_req), 32'd0);
    check("arst_id_valid", !id_valid, 32'(id_valid), 32'd0);
    check("arst_id_pc2", id_pc_plus2 == 16'd0, 32'(id_pc_plus2), 32'd0);
    check("arst_halted", !halted, 32'(halted), 32'd0);
    repeat (2) @(negedge clk);
    restart(RST_PC);
    rst_n = 1'b1;
    @(negedge clk);
    #4;
    check("post_rst_addr", bus.imem_req && bus.imem_addr == RST_PC,
          {15'd0, bus.imem_req, bus.imem_addr}, {16'd1, RST_PC});

    repeat (500) step_random();

    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    repeat (20) @(negedge clk);
    check("progress", n_consumed >= 150, 32'(n_consumed), 32'd150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
